// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte+error FIFO behind uart_receiver, registered pop, sticky overrun.
// Optional UART_RX_FIFO_THRESH_EN adds parameter THRESH and output thresh_hit.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  parameter int THRESH = DEPTH / 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_err,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  output logic              thresh_hit
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rx_ready_q;
  logic              wr;
  logic              push;
  logic              pop;
  logic              drop;
  logic [ADDR_W:0]   count_n;

  assign wr   = rx_ready & ~rx_ready_q;
  assign pop  = rd_en & ~empty;
  // At full a same-cycle pop frees the slot, so the push is kept
  assign push = wr & (~full | rd_en);
  assign drop = wr & full & ~rd_en;

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + ONE_C;
    else if (pop && !push)
      count_n = count - ONE_C;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {rx_error, rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      rd_data    <= 8'h00;
      rd_err     <= 1'b0;
      rd_valid   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      rd_valid   <= pop;
      count      <= count_n;
      empty      <= (count_n == '0);
      full       <= (count_n == DEPTH_C);
      if (push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        {rd_err, rd_data} <= mem[rd_ptr];
        rd_ptr            <= rd_ptr + ADDR_W'(1);
      end
      if (drop)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      thresh_hit <= 1'b0;
    else
      thresh_hit <= (count_n >= THRESH_C);
  end
`endif

endmodule
